// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS-lite core: FETCH/DECODE/EXEC/MEM/WB control over one shared
// req/ready memory port, internal 32x32 register file, retire counter and halt flag.
module mips_multicycle #(
    parameter int          ADDR_W   = 12,
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       pc_o,
    output logic [CNT_W-1:0]  instret,
    output logic              halted
);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_ORI = 6'h0d, OP_LUI = 6'h0f;
    localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2b;
    localparam logic [5:0] F_JR = 6'h08, F_ADDU = 6'h21, F_SUBU = 6'h23, F_SLT = 6'h2a;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d, ir_q, ir_d, pcp4_q, pcp4_d;
    logic [31:0]        a_q, a_d, b_q, b_d, res_q, res_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   instret_q;
    logic [31:0]        gpr_q [32];

    logic               retire, gpr_we, legal, alu_ovf;
    logic [4:0]         gpr_wa;
    logic [31:0]        gpr_wd, alu_res;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] imm_sx, imm_zx;
    logic        unused_shamt;

    assign op           = ir_q[31:26];
    assign rs           = ir_q[25:21];
    assign rt           = ir_q[20:16];
    assign rd           = ir_q[15:11];
    assign funct        = ir_q[5:0];
    assign imm          = ir_q[15:0];
    assign imm_sx       = {{16{imm[15]}}, imm};
    assign imm_zx       = {16'h0000, imm};
    assign unused_shamt = ^ir_q[10:6];

    always_comb begin
        case (op)
            OP_R:    legal = (funct == F_ADDU) || (funct == F_SUBU) ||
                             (funct == F_SLT)  || (funct == F_JR);
            OP_J, OP_JAL, OP_BEQ, OP_ADDI, OP_ADDIU,
            OP_ORI, OP_LUI, OP_LW, OP_SW: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        alu_res = 32'h0;
        alu_ovf = 1'b0;
        case (op)
            OP_R: begin
                case (funct)
                    F_ADDU:  alu_res = a_q + b_q;
                    F_SUBU:  alu_res = a_q - b_q;
                    F_SLT:   alu_res = {31'h0, $signed(a_q) < $signed(b_q)};
                    default: alu_res = 32'h0;
                endcase
            end
            OP_ADDI: begin
                alu_res = a_q + imm_sx;
                alu_ovf = (a_q[31] == imm_sx[31]) && (alu_res[31] != a_q[31]);
            end
            OP_ADDIU, OP_LW, OP_SW: alu_res = a_q + imm_sx;
            OP_ORI:  alu_res = a_q | imm_zx;
            OP_LUI:  alu_res = {imm, 16'h0000};
            default: alu_res = 32'h0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        pcp4_d  = pcp4_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        retire  = 1'b0;
        gpr_we  = 1'b0;
        gpr_wa  = 5'd0;
        gpr_wd  = 32'h0;
        case (state_q)
            S_FETCH: if (mem_ready) begin
                ir_d    = mem_rdata;
                pcp4_d  = pc_q + 32'd4;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                a_d     = gpr_q[rs];
                b_d     = gpr_q[rt];
                state_d = legal ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                res_d   = alu_res;
                ovf_d   = alu_ovf;
                pc_d    = pcp4_q;
                retire  = 1'b1;
                state_d = S_FETCH;
                case (op)
                    OP_BEQ: if (a_q == b_q) pc_d = pcp4_q + {imm_sx[29:0], 2'b00};
                    OP_J:   pc_d = {pcp4_q[31:28], ir_q[25:0], 2'b00};
                    OP_JAL: begin
                        pc_d   = {pcp4_q[31:28], ir_q[25:0], 2'b00};
                        gpr_we = 1'b1;
                        gpr_wa = 5'd31;
                        gpr_wd = pcp4_q;
                    end
                    OP_LW, OP_SW: begin
                        retire  = 1'b0;
                        state_d = S_MEM;
                    end
                    default: if (!(op == OP_R && funct == F_JR)) begin
                        retire  = 1'b0;
                        state_d = S_WB;
                    end else begin
                        pc_d = a_q;
                    end
                endcase
            end
            S_MEM: if (mem_ready) begin
                if (op == OP_SW) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    res_d   = mem_rdata;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                // addi overflow drops the write but still retires
                gpr_we  = !ovf_q;
                gpr_wa  = (op == OP_R) ? rd : rt;
                gpr_wd  = res_q;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= 32'h0;
            pcp4_q    <= 32'h0;
            a_q       <= 32'h0;
            b_q       <= 32'h0;
            res_q     <= 32'h0;
            ovf_q     <= 1'b0;
            instret_q <= '0;
            for (int i = 0; i < 32; i++) gpr_q[i] <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            pcp4_q  <= pcp4_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            if (retire) instret_q <= instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (gpr_we && gpr_wa != 5'd0) gpr_q[gpr_wa] <= gpr_wd;
        end
    end

    // Request is gated by reset so an in-flight access is abandoned immediately.
    assign mem_req   = rst && (state_q == S_FETCH || state_q == S_MEM);
    assign mem_we    = rst && (state_q == S_MEM) && (op == OP_SW);
    assign mem_addr  = (state_q == S_MEM) ? {res_q[ADDR_W-1:2], 2'b00}
                                          : {pc_q[ADDR_W-1:2], 2'b00};
    assign mem_wdata = b_q;
    assign pc_o      = pc_q;
    assign instret   = instret_q;
    assign halted    = (state_q == S_HALT);

endmodule
